cbfp_norm_pp: RTL and testbench
===============================

Name: cbfp_norm_pp

Overview:
- Parametrised convergent block-floating-point normaliser. Successor to the fixed stage-0 CBFP.
- Collects BLOCK_SIZE complex samples arriving BATCH_SIZE per beat and finds the block exponent (minimum redundant sign bits over all re/im values). Re-emits the block scaled to BW_OUT bits with its exponent index.
- Ping-pong banks give full throughput. A valid/ready handshake on both sides supports backpressure. Sits between butterfly stages of the FFT pipeline.

Parameters:
- BW_IN, 23, input sample width (signed).
- BW_OUT, 11, output sample width (signed); BW_OUT < BW_IN.
- BLOCK_SIZE, 64, samples per normalisation block; multiple of BATCH_SIZE.
- BATCH_SIZE, 16, samples per beat.
- MAX_SHIFT, BW_IN-1, upper clamp on applied exponent.
- ROUND, 0: 0 = floor (arithmetic truncation); 1 = round-half-up with saturation.
- Localparams: BEATS = BLOCK_SIZE/BATCH_SIZE; IDX_W = $clog2(BW_IN).

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- cbfp_en, in, 1, 0 forces exponent 0 (pure truncation). Sampled on the first beat of each block.
- in_valid, in, 1, input beat valid.
- in_ready, out, 1, write bank free.
- in_re / in_im, in, BATCH_SIZE x BW_IN signed, input beat.
- out_valid, out, 1, output beat valid.
- out_ready, in, 1, downstream accepts.
- out_re / out_im, out, BATCH_SIZE x BW_OUT signed, normalised beat.
- out_index, out, IDX_W, block exponent applied.
- out_last, out, 1, final beat of the block.

Behaviour:
- Reset (synchronous, rst=1 at posedge): both banks empty, beat counters 0. out_valid, out_last, out_re, out_im and out_index are 0. in_ready is 1 in the cycle after reset. A partial block in flight is discarded.
- A beat is accepted when in_valid && in_ready. Beats with in_ready=0 are ignored (no state change).
- Write side: beat k (0..BEATS-1) is written to the write bank at slots k*BATCH_SIZE+i.
- Running min: per sample lz = (count of leading bits equal to MSB) - 1, range 0..BW_IN-1; zero gives BW_IN-1. The bank min is seeded by beat 0 and updated each beat.
- On accepting beat BEATS-1, at the same edge:
  - bank marked full;
  - e = cbfp_en_captured ? min(run_min, MAX_SHIFT) : 0 is registered;
  - write pointer toggles.
- in_ready = write bank not full.
- Read side: the output register loads when (!out_valid || out_ready) and the read bank is full.
  - Beat j gets BATCH_SIZE samples of slot j*BATCH_SIZE+i.
  - out_index = e; out_last = (j == BEATS-1).
  - After beat BEATS-1 loads, the bank is freed and the read pointer toggles.
  - Output holds stable while out_valid && !out_ready.
- Latency: first output beat is valid 2 cycles after the last input beat is accepted, if the output path is idle. With out_ready=1 the block streams one beat per cycle and the next full bank follows with no bubble.
- Arithmetic: y = (x <<< e) >>> (BW_IN-BW_OUT), taken as bits [BW_IN-1 : BW_IN-BW_OUT] of the BW_IN-wide shifted value. No overflow is possible since e ≤ lz.
  - ROUND=1: add 2^(BW_IN-BW_OUT-1) before the shift in a BW_IN+1-bit accumulator, then saturate to [-2^(BW_OUT-1), 2^(BW_OUT-1)-1].
- Same-edge free and fill: a bank freed by the read side at the same edge the write side needs it allows in_ready=1 the next cycle. Never a combinational ready path from out_ready to in_ready.
- Both banks full: in_ready=0 until the read side frees one.
- Exponent is per-block only. No carry-over between blocks. Each bank stores its own e and cbfp_en.

Test Plan:
- Defaults; one block with max |sample| 1000 and other samples 3 or -5 -> out_index=12; 1000→1000, 3→3, -5→-5; out_last on beat 4 only; first out_valid 2 cycles after last in beat.
- Block containing -4194304 and 4095 -> out_index=0; -4194304→-1024, 4095→0, -4097→-2 (floor).
- All-zero block -> out_index=22, all outputs 0. Same max-1000 block with cbfp_en=0 -> out_index=0, 1000→0.
- ROUND=1, block with 4194303 -> e=0, output saturates to 1023; 2048→1, 2047→0.
- out_ready=0, three blocks offered back-to-back -> 8 beats accepted, then in_ready=0. Raise out_ready -> block A beats 1–4 then B beats 5–8 with no bubble, out_last on beats 4 and 8, then block C accepted. Stall mid-block holds out_re/out_im stable.
- Two beats of a block, then rst=1 for one cycle -> out_valid=0, in_ready=1. The next full block with max 1000 outputs index 12, unaffected by the discarded beats.

Source files
------------

// File: rtl/cbfp_norm_pp.sv
// cbfp_norm_pp: convergent block-floating-point normaliser with ping-pong banks.
// Collects BLOCK_SIZE complex samples (BATCH_SIZE per beat), finds the smallest
// count of redundant sign bits over the block and re-emits the block scaled to
// BW_OUT bits together with the exponent that was applied.
module cbfp_norm_pp #(
  parameter int BW_IN      = 23,
  parameter int BW_OUT     = 11,
  parameter int BLOCK_SIZE = 64,
  parameter int BATCH_SIZE = 16,
  parameter int MAX_SHIFT  = BW_IN - 1,
  parameter int ROUND      = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cbfp_en,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [BATCH_SIZE*BW_IN-1:0]      in_re,
  input  logic [BATCH_SIZE*BW_IN-1:0]      in_im,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [BATCH_SIZE*BW_OUT-1:0]     out_re,
  output logic [BATCH_SIZE*BW_OUT-1:0]     out_im,
  output logic [$clog2(BW_IN)-1:0]         out_index,
  output logic                             out_last
);

  localparam int BEATS = BLOCK_SIZE / BATCH_SIZE;
  localparam int IDX_W = $clog2(BW_IN);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SHR   = BW_IN - BW_OUT;

  localparam logic [BW_IN:0]    HALF    = (BW_IN+1)'(1) << (SHR - 1);
  localparam logic [BW_OUT-1:0] SAT_MAX = {1'b0, {(BW_OUT-1){1'b1}}};
  localparam logic [BW_OUT-1:0] SAT_MIN = {1'b1, {(BW_OUT-1){1'b0}}};

  // Redundant sign bits: leading bits equal to the MSB, minus the MSB itself.
  function automatic logic [IDX_W-1:0] red_sign(input logic [BW_IN-1:0] x);
    logic [IDX_W-1:0] n;
    logic             run;
    n   = '0;
    run = 1'b1;
    for (int i = BW_IN - 2; i >= 0; i--) begin
      if (run && (x[i] == x[BW_IN-1])) n = n + 1'b1;
      else                             run = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [IDX_W-1:0] min_idx(input logic [IDX_W-1:0] a,
                                               input logic [IDX_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Shift left by the block exponent, keep the top BW_OUT bits; the rounding
  // variant adds half an output LSB in a one-bit-wider accumulator and saturates.
  function automatic logic [BW_OUT-1:0] scale(input logic [BW_IN-1:0] x,
                                              input logic [IDX_W-1:0] e);
    logic [BW_IN-1:0]        sh;
    logic signed [BW_IN:0]   acc;
    logic [BW_OUT:0]         q;
    logic [BW_OUT-1:0]       y;
    sh  = x << e;
    acc = $signed({sh[BW_IN-1], sh} + HALF);
    q   = (BW_OUT+1)'(acc >>> SHR);
    if (ROUND == 0)                  y = BW_OUT'(sh >> SHR);
    else if (q[BW_OUT] != q[BW_OUT-1]) y = q[BW_OUT] ? SAT_MIN : SAT_MAX;
    else                             y = q[BW_OUT-1:0];
    return y;
  endfunction

  logic                         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]             wr_cnt, rd_cnt;
  logic [1:0]                   full;
  logic [IDX_W-1:0]             run_min;
  logic                         en_cap;
  logic [IDX_W-1:0]             bank_e [2];
  logic [1:0]                   bank_en;
  logic [BATCH_SIZE*BW_IN-1:0]  mem_re [2][BEATS];
  logic [BATCH_SIZE*BW_IN-1:0]  mem_im [2][BEATS];

  logic                         wr_fire, wr_last, rd_load, rd_last;
  logic [IDX_W-1:0]             beat_min, blk_min, blk_e, rd_e;
  logic                         en_blk;
  logic [BATCH_SIZE*BW_IN-1:0]  rd_beat_re, rd_beat_im;
  logic [BATCH_SIZE*BW_OUT-1:0] nxt_re, nxt_im;

  // Ready depends only on registered bank state, so out_ready never reaches in_ready.
  assign in_ready = !full[wr_ptr];
  assign wr_fire  = in_valid && in_ready;
  assign wr_last  = wr_fire && (wr_cnt == CNT_W'(BEATS - 1));
  assign rd_load  = (!out_valid || out_ready) && full[rd_ptr];
  assign rd_last  = rd_load && (rd_cnt == CNT_W'(BEATS - 1));

  // Beat 0 seeds the running minimum and captures cbfp_en for the whole block.
  assign blk_min = (wr_cnt == '0) ? beat_min : min_idx(run_min, beat_min);
  assign blk_e   = min_idx(blk_min, IDX_W'(MAX_SHIFT));
  assign en_blk  = (wr_cnt == '0) ? cbfp_en : en_cap;

  assign rd_beat_re = mem_re[rd_ptr][rd_cnt];
  assign rd_beat_im = mem_im[rd_ptr][rd_cnt];
  assign rd_e       = bank_en[rd_ptr] ? bank_e[rd_ptr] : '0;

  // Minimum redundant-sign count over every re/im value of the incoming beat.
  always_comb begin
    // NOTE: assign a default before any conditional or looped update so no latch is inferred.
    beat_min = IDX_W'(BW_IN - 1);
    for (int i = 0; i < BATCH_SIZE; i++) begin
      beat_min = min_idx(beat_min, red_sign(in_re[i*BW_IN +: BW_IN]));
      beat_min = min_idx(beat_min, red_sign(in_im[i*BW_IN +: BW_IN]));
    end
  end

  // Scaled version of the read-bank beat that the output register loads next.
  always_comb begin
    nxt_re = '0;
    nxt_im = '0;
    for (int i = 0; i < BATCH_SIZE; i++) begin
      nxt_re[i*BW_OUT +: BW_OUT] = scale(rd_beat_re[i*BW_IN +: BW_IN], rd_e);
      nxt_im[i*BW_OUT +: BW_OUT] = scale(rd_beat_im[i*BW_IN +: BW_IN], rd_e);
    end
  end

  // Sample storage: beat k of a block lands in slot k of the write bank.
  always_ff @(posedge clk) begin
    // NOTE: the banks are deliberately not reset; the full flags say which contents are live.
    if (wr_fire) begin
      mem_re[wr_ptr][wr_cnt] <= in_re;
      mem_im[wr_ptr][wr_cnt] <= in_im;
    end
  end

  // Bank control and the output register; fill and free of opposite banks may share an edge.
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every read sees pre-edge values.
    if (rst) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      full      <= '0;
      run_min   <= '0;
      en_cap    <= 1'b0;
      bank_en   <= '0;
      for (int b = 0; b < 2; b++) bank_e[b] <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_index <= '0;
    end else begin
      if (wr_fire) begin
        run_min <= blk_min;
        en_cap  <= en_blk;
        if (wr_last) begin
          full[wr_ptr]    <= 1'b1;
          bank_e[wr_ptr]  <= blk_e;
          bank_en[wr_ptr] <= en_blk;
          wr_ptr          <= !wr_ptr;
          wr_cnt          <= '0;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end

      if (rd_load) begin
        out_valid <= 1'b1;
        out_re    <= nxt_re;
        out_im    <= nxt_im;
        out_index <= rd_e;
        out_last  <= (rd_cnt == CNT_W'(BEATS - 1));
        if (rd_last) begin
          full[rd_ptr] <= 1'b0;
          rd_ptr       <= !rd_ptr;
          rd_cnt       <= '0;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cbfp_norm_pp.sv
// Testbench for cbfp_norm_pp: a floor instance and a rounding instance share
// the same stimulus; a block-level arithmetic model predicts every output beat.
module tb_cbfp_norm_pp;

  localparam int BW_IN     = 23;
  localparam int BW_OUT    = 11;
  localparam int BLOCK     = 64;
  localparam int BATCH     = 16;
  localparam int BEATS     = BLOCK / BATCH;
  localparam int IDX_W     = $clog2(BW_IN);
  localparam int MAX_SHIFT = BW_IN - 1;
  localparam int SHR       = BW_IN - BW_OUT;

  logic clk = 1'b0;
  logic rst, cbfp_en, in_valid, out_ready;
  logic [BATCH*BW_IN-1:0]  in_re, in_im;
  logic                    in_ready0, in_ready1, out_valid0, out_valid1, out_last0, out_last1;
  logic [BATCH*BW_OUT-1:0] out_re0, out_im0, out_re1, out_im1;
  logic [IDX_W-1:0]        out_index0, out_index1;

  int errors = 0;
  int checks = 0;
  bit rand_mode = 1'b0;

  always #5 clk = ~clk;

  cbfp_norm_pp #(.ROUND(0)) u_floor (
    .clk(clk), .rst(rst), .cbfp_en(cbfp_en), .in_valid(in_valid), .in_ready(in_ready0),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid0), .out_ready(out_ready),
    .out_re(out_re0), .out_im(out_im0), .out_index(out_index0), .out_last(out_last0));

  cbfp_norm_pp #(.ROUND(1)) u_round (
    .clk(clk), .rst(rst), .cbfp_en(cbfp_en), .in_valid(in_valid), .in_ready(in_ready1),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid1), .out_ready(out_ready),
    .out_re(out_re1), .out_im(out_im1), .out_index(out_index1), .out_last(out_last1));

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint samp(input logic [BATCH*BW_OUT-1:0] v, input int i);
    return longint'($signed(v[i*BW_OUT +: BW_OUT]));
  endfunction

  // Redundant sign bits: largest n such that x fits in BW_IN-n signed bits.
  function automatic int model_lz(input longint x);
    longint lim;
    for (int n = BW_IN - 1; n >= 0; n--) begin
      lim = longint'(1) <<< (BW_IN - 1 - n);
      if (x >= -lim && x < lim) return n;
    end
    return 0;
  endfunction

  // y = floor(x * 2^e / 2^SHR); rounding adds half an LSB first and saturates.
  function automatic longint model_scale(input longint x, input int e, input bit rnd);
    longint v;
    v = x * (longint'(1) <<< e);
    if (!rnd) return v >>> SHR;
    v = (v + (longint'(1) <<< (SHR - 1))) >>> SHR;
    if (v > (longint'(1) <<< (BW_OUT - 1)) - 1) v = (longint'(1) <<< (BW_OUT - 1)) - 1;
    if (v < -(longint'(1) <<< (BW_OUT - 1)))    v = -(longint'(1) <<< (BW_OUT - 1));
    return v;
  endfunction

  // ---------------- reference model and scoreboard ----------------
  longint blk_re [BLOCK];
  longint blk_im [BLOCK];
  int     m_beat = 0;
  bit     m_en;
  longint exp_val [$];
  int     exp_idx [$];
  bit     exp_last [$];

  task automatic push_block();
    int minlz, e;
    minlz = BW_IN - 1;
    for (int k = 0; k < BLOCK; k++) begin
      if (model_lz(blk_re[k]) < minlz) minlz = model_lz(blk_re[k]);
      if (model_lz(blk_im[k]) < minlz) minlz = model_lz(blk_im[k]);
    end
    e = m_en ? ((minlz < MAX_SHIFT) ? minlz : MAX_SHIFT) : 0;
    for (int b = 0; b < BEATS; b++) begin
      exp_idx.push_back(e);
      exp_last.push_back(b == BEATS - 1);
      for (int i = 0; i < BATCH; i++) begin
        exp_val.push_back(model_scale(blk_re[b*BATCH+i], e, 1'b0));
        exp_val.push_back(model_scale(blk_im[b*BATCH+i], e, 1'b0));
        exp_val.push_back(model_scale(blk_re[b*BATCH+i], e, 1'b1));
        exp_val.push_back(model_scale(blk_im[b*BATCH+i], e, 1'b1));
      end
    end
  endtask

  logic [BATCH*BW_OUT-1:0] p_re0, p_im0, p_re1, p_im1;
  logic [IDX_W-1:0]        p_idx0, p_idx1;
  logic                    p_last0, p_last1;
  bit                      hold_v = 1'b0;

  // Compare process: observes handshakes half a cycle before the edge that acts on them.
  always @(negedge clk) begin
    if (rst) begin
      m_beat = 0;
      exp_val.delete();
      exp_idx.delete();
      exp_last.delete();
      hold_v = 1'b0;
    end else begin
      check("in_ready match", in_ready1, in_ready0);
      check("out_valid match", out_valid1, out_valid0);
      if (in_valid && in_ready0) begin
        if (m_beat == 0) m_en = cbfp_en;
        for (int i = 0; i < BATCH; i++) begin
          blk_re[m_beat*BATCH+i] = longint'($signed(in_re[i*BW_IN +: BW_IN]));
          blk_im[m_beat*BATCH+i] = longint'($signed(in_im[i*BW_IN +: BW_IN]));
        end
        m_beat++;
        if (m_beat == BEATS) begin
          push_block();
          m_beat = 0;
        end
      end
      if (hold_v)
        check("hold stable", (out_valid0 && out_re0 == p_re0 && out_im0 == p_im0 &&
                              out_re1 == p_re1 && out_im1 == p_im1 && out_index0 == p_idx0 &&
                              out_index1 == p_idx1 && out_last0 == p_last0 &&
                              out_last1 == p_last1), 1);
      if (out_valid0 && out_ready) begin
        if (exp_idx.size() == 0) begin
          check("out beat expected", exp_idx.size(), 1);
        end else begin
          int  ei;
          bit  el;
          ei = exp_idx.pop_front();
          el = exp_last.pop_front();
          check("index floor", out_index0, ei);
          check("index round", out_index1, ei);
          check("last floor", out_last0, el);
          check("last round", out_last1, el);
          for (int i = 0; i < BATCH; i++) begin
            check("re floor", samp(out_re0, i), exp_val.pop_front());
            check("im floor", samp(out_im0, i), exp_val.pop_front());
            check("re round", samp(out_re1, i), exp_val.pop_front());
            check("im round", samp(out_im1, i), exp_val.pop_front());
          end
        end
      end
      hold_v  = out_valid0 && !out_ready;
      p_re0   = out_re0;   p_im0  = out_im0;   p_re1 = out_re1; p_im1 = out_im1;
      p_idx0  = out_index0; p_idx1 = out_index1;
      p_last0 = out_last0;  p_last1 = out_last1;
    end
  end

  // ---------------- stimulus ----------------
  longint stim_re [BLOCK];
  longint stim_im [BLOCK];

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // kind 0: max 1000 with 3/-5 filler; 1: floor corner values; 2: zeros;
  // 3: rounding corner values; 4: random magnitude.
  task automatic fill_block(input int kind);
    int     w;
    longint m;
    w = $urandom_range(0, BW_IN - 1);
    for (int k = 0; k < BLOCK; k++) begin
      case (kind)
        0: begin
          stim_re[k] = (k == 0) ? 1000 : ((k % 2) ? -5 : 3);
          stim_im[k] = (k % 2) ? 3 : -5;
        end
        1, 2, 3: begin
          stim_re[k] = 0;
          stim_im[k] = 0;
        end
        default: begin
          m = longint'($urandom) & ((longint'(1) <<< w) - 1);
          stim_re[k] = $urandom_range(0, 1) ? -m - 1 : m;
          m = longint'($urandom) & ((longint'(1) <<< w) - 1);
          stim_im[k] = $urandom_range(0, 1) ? -m - 1 : m;
        end
      endcase
    end
    if (kind == 1) begin
      stim_re[0] = -4194304; stim_re[1] = 4095; stim_re[2] = -4097;
    end
    if (kind == 3) begin
      stim_re[0] = 4194303;  stim_re[1] = 2048; stim_re[2] = 2047;
    end
  endtask

  task automatic send_beat(input int b);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < BATCH; i++) begin
      in_re[i*BW_IN +: BW_IN] = BW_IN'(stim_re[b*BATCH+i]);
      in_im[i*BW_IN +: BW_IN] = BW_IN'(stim_im[b*BATCH+i]);
    end
    in_valid = 1'b1;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready0;
      tick();
    end
    in_valid = 1'b0;
    check("in_ready wait", ok, 1);
  endtask

  task automatic send_block();
    for (int b = 0; b < BEATS; b++) send_beat(b);
  endtask

  // Waits for a block with out_ready held high and checks literal expectations.
  task automatic check_block(input int inst, input longint idx, input longint s0,
                             input longint s1, input longint s2, output int waited);
    bit found;
    found  = 1'b0;
    waited = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (out_valid0) found = 1'b1;
      else begin
        waited++;
        tick();
      end
    end
    check("block out_valid", found, 1);
    if (found) begin
      check("block index", inst ? out_index1 : out_index0, idx);
      check("block sample0", samp(inst ? out_re1 : out_re0, 0), s0);
      check("block sample1", samp(inst ? out_re1 : out_re0, 1), s1);
      check("block sample2", samp(inst ? out_re1 : out_re0, 2), s2);
      for (int j = 0; j < BEATS; j++) begin
        if (j > 0) @(negedge clk);
        check("block beat valid", out_valid0, 1);
        check("block beat last", inst ? out_last1 : out_last0, j == BEATS - 1);
        tick();
      end
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      if (exp_idx.size() == 0 && !out_valid0) done = 1'b1;
      else tick();
    end
    check("drain pending beats", exp_idx.size(), 0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    logic [BATCH*BW_OUT-1:0] s_re, s_im;
    rst = 1'b1; cbfp_en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_re = '0; in_im = '0;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset out_valid", out_valid0, 0);
    check("reset out_last", out_last0, 0);
    check("reset out_index", out_index0, 0);
    check("reset out_re zero", (out_re0 == '0 && out_im0 == '0), 1);
    check("reset in_ready", in_ready0, 1);
    tick();

    // Max-1000 block: exponent 12, values preserved, two-cycle latency
    fill_block(0);
    send_block();
    @(negedge clk);
    check("latency early out_valid", out_valid0, 0);
    tick();
    check_block(0, 12, 1000, -5, 3, waited);
    check("latency cycles", waited, 0);

    // Full-scale negative forces exponent 0, floor truncation
    fill_block(1);
    send_block();
    check_block(0, 0, -1024, 0, -2, waited);

    // All-zero block
    fill_block(2);
    send_block();
    check_block(0, 22, 0, 0, 0, waited);

    // cbfp_en low: pure truncation
    fill_block(0);
    cbfp_en = 1'b0;
    send_block();
    cbfp_en = 1'b1;
    check_block(0, 0, 0, -1, 0, waited);

    // Rounding instance: saturation and half-LSB rounding
    fill_block(3);
    send_block();
    check_block(1, 0, 1023, 1, 0, waited);

    // Backpressure: two blocks fill both banks, third is refused
    out_ready = 1'b0;
    fill_block(4); send_block();
    fill_block(4); send_block();
    fill_block(4);
    for (int i = 0; i < BATCH; i++) begin
      in_re[i*BW_IN +: BW_IN] = BW_IN'(stim_re[i]);
      in_im[i*BW_IN +: BW_IN] = BW_IN'(stim_im[i]);
    end
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("both full in_ready", in_ready0, 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 2 * BEATS; k++) begin
      @(negedge clk);
      check("stream no bubble", out_valid0, 1);
      check("stream out_last", out_last0, (k % BEATS) == BEATS - 1);
      tick();
    end
    send_block();

    // Stall mid-block holds the output
    begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
        @(negedge clk);
        seen = out_valid0;
        tick();
      end
      check("stall block appears", seen, 1);
    end
    out_ready = 1'b0;
    @(negedge clk);
    s_re = out_re0; s_im = out_im0;
    repeat (3) tick();
    @(negedge clk);
    check("stall hold data", (out_valid0 && out_re0 == s_re && out_im0 == s_im), 1);
    tick();
    out_ready = 1'b1;
    wait_drain();

    // Reset in the middle of a block discards the partial data
    fill_block(1);
    send_beat(0);
    send_beat(1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid reset out_valid", out_valid0, 0);
    check("mid reset in_ready", in_ready0, 1);
    tick();
    fill_block(0);
    send_block();
    check_block(0, 12, 1000, -5, 3, waited);

    // Randomised blocks, gaps, cbfp_en toggling after beat 0, random backpressure
    rand_mode = 1'b1;
    for (int blk = 0; blk < 40; blk++) begin
      fill_block(4);
      cbfp_en = ($urandom_range(0, 3) != 0);
      for (int b = 0; b < BEATS; b++) begin
        if (b > 0) cbfp_en = $urandom_range(0, 1);
        repeat ($urandom_range(0, 2)) tick();
        send_beat(b);
      end
    end
    rand_mode = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
